// File: rtl/demux_pkg.sv
// Shared definitions for the demux dispatch block.
//   NUM_CH / CH_W : number of demux outputs and width of the select bus
//   demux_req_t   : one routing request (target channel plus data bit)
//   state_t       : dispatcher state (IDLE: nothing presented, DRIVE: request on din/sel)
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            bit_v;
    } demux_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/demux_dispatch_if.sv
// Request handshake between a producer and the demux dispatcher.
//   in_valid : producer has a request on in_ch/in_bit
//   in_ready : dispatcher can accept it this cycle
//   in_ch    : target demux channel
//   in_bit   : value to route to that channel
// Modports: master = producer side, slave = dispatcher side.
interface demux_dispatch_if;
    import demux_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic            in_bit;

    modport master (output in_valid, output in_ch, output in_bit, input in_ready);
    modport slave  (input in_valid, input in_ch, input in_bit, output in_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : advance the read pointer (ignored when empty)
//   flush_i    : discard all contents; wins over push and pop
//   rdata_o    : head entry (valid when !empty_o)
//   full_o, empty_o, level_o : status
// Pointers carry one extra wrap bit so full and empty are distinguishable
// with all DEPTH slots in use.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign level_o = LW'(count);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage holds only data; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/demux_dispatch.sv
// Feeder for an 8-way 1-bit demultiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_if     : request handshake (slave modport: in_valid/in_ready/in_ch/in_bit)
//   flush      : synchronous discard of the queue and the request being presented
//   din, sel   : registered data/select pair driving the demux
//   active     : a request is currently being presented on din/sel
//   level      : queued entries, not counting the one being presented
// Accepted requests are buffered and each is held on din/sel for HOLD cycles,
// back-to-back while more are queued. din returns to 0 when idle so that no
// demux output is asserted; sel keeps its last value.
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    demux_dispatch_if.slave            req_if,
    input  logic                       flush,
    output logic                       din,
    output logic [CH_W-1:0]            sel,
    output logic                       active,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("demux_dispatch: DEPTH must be a power of two and >= 2");
    end
    if (HOLD < 1) begin : g_bad_hold
        $error("demux_dispatch: HOLD must be >= 1");
    end

    state_t          state_q;
    logic            din_q;
    logic [CH_W-1:0] sel_q;
    logic            active_q;
    logic [CNT_W-1:0] cnt_q;

    demux_req_t wreq;
    demux_req_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       last_cycle;

    // Ready never looks at in_valid, and a pop in the same cycle does not
    // open a slot early when full. It is held low throughout reset.
    assign req_if.in_ready = rst_n && !fifo_full && !flush;
    assign push            = req_if.in_valid && req_if.in_ready;

    assign wreq.ch    = req_if.in_ch;
    assign wreq.bit_v = req_if.in_bit;

    assign last_cycle = (cnt_q == CNT_LAST);

    // Take the next entry when idle, or on the final hold cycle so the
    // following request starts with no gap.
    assign pop = !flush && !fifo_empty && ((state_q == IDLE) || last_cycle);

    sync_fifo #(
        .WIDTH ($bits(demux_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wreq),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            din_q    <= 1'b0;
            sel_q    <= '0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (flush) begin
            // sel is deliberately left alone: only din gates the demux.
            state_q  <= IDLE;
            din_q    <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        din_q    <= head.bit_v;
                        sel_q    <= head.ch;
                        active_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (last_cycle) begin
                        if (pop) begin
                            din_q    <= head.bit_v;
                            sel_q    <= head.ch;
                            active_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            din_q    <= 1'b0;
                            active_q <= 1'b0;
                            cnt_q    <= '0;
                            state_q  <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign din    = din_q;
    assign sel    = sel_q;
    assign active = active_q;

endmodule

// File: tb/tb_demux_dispatch.sv
// Scoreboard bench for demux_dispatch. The driver keeps an abstract model
// (queue of waiting requests plus cycles left on the current one) and pushes
// every accepted request into exp_q; an independent monitor pops exp_q each
// time the DUT starts presenting a request and checks content and hold time.
module tb_demux_dispatch;
    import demux_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic                       clk;
    logic                       rst_n;
    logic                       flush;
    logic                       din;
    logic [CH_W-1:0]            sel;
    logic                       active;
    logic [$clog2(DEPTH+1)-1:0] level;

    demux_dispatch_if bus ();

    demux_dispatch #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_if (bus),
        .flush  (flush),
        .din    (din),
        .sel    (sel),
        .active (active),
        .level  (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    demux_req_t exp_q[$];   // scoreboard: requests in acceptance order
    demux_req_t pend[$];    // model: accepted but not yet presented
    int         left = 0;   // model: cycles remaining on current presentation
    logic       flush_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model step for that edge.
    task automatic cycle(input logic v, input logic [2:0] c, input logic b,
                         input logic f, output logic acc);
        logic       rdy_m;
        demux_req_t r;
        @(negedge clk);
        chk("level", 32'(level), 32'(pend.size()));
        chk("active", 32'(active), 32'(left > 0));
        bus.in_valid = v;
        bus.in_ch    = c;
        bus.in_bit   = b;
        flush        = f;
        #1;
        rdy_m = (pend.size() < DEPTH) && !f;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
        @(posedge clk);
        acc     = v && rdy_m;
        r.ch    = c;
        r.bit_v = b;
        if (f) begin
            pend.delete();
            exp_q.delete();
            left       = 0;
            flush_seen = 1'b1;
        end else begin
            if (left > 0) left--;
            if (pend.size() > 0 && left == 0) begin
                void'(pend.pop_front());
                left = HOLD;
            end
            if (acc) begin
                pend.push_back(r);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, 1'b0, acc);
    endtask

    task automatic push_wait(input logic [2:0] c, input logic b);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            cycle(1'b1, c, b, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: ch=%0d not accepted within %0d cycles", c, tries);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        pend.delete();
        exp_q.delete();
        left = 0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: checks what the demux actually sees, independent of the driver.
    initial begin
        int              run;
        logic [CH_W-1:0] last_sel;
        demux_req_t      cur;
        run      = 0;
        last_sel = '0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run        = 0;
                last_sel   = '0;
                flush_seen = 1'b0;
            end else if (active) begin
                if (run == 0 || run == HOLD) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_present: sel=%0d din=%0b with nothing queued", sel, din);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("present_sel", 32'(sel), 32'(cur.ch));
                        chk("present_din", 32'(din), 32'(cur.bit_v));
                    end
                    run = 1;
                end else begin
                    chk("hold_sel", 32'(sel), 32'(cur.ch));
                    chk("hold_din", 32'(din), 32'(cur.bit_v));
                    run++;
                end
                last_sel = sel;
            end else begin
                chk("idle_din", 32'(din), 32'd0);
                chk("idle_sel", 32'(sel), 32'(last_sel));
                if (run != 0 && run != HOLD && !flush_seen)
                    chk("hold_len", 32'(run), 32'(HOLD));
                run        = 0;
                flush_seen = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_bit   = 1'b0;
        #1;
        chk("init_din", 32'(din), 32'd0);
        chk("init_sel", 32'(sel), 32'd0);
        chk("init_active", 32'(active), 32'd0);
        chk("init_level", 32'(level), 32'd0);
        chk("init_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single request, then idle with sel retained.
        push_wait(3'd5, 1'b1);
        idle(5);

        // All eight channels back to back.
        for (int ch = 0; ch < 8; ch++) push_wait(3'(ch), 1'b1);
        idle(20);

        // Keep valid high long enough to fill the FIFO and hit backpressure.
        for (int i = 0; i < 14; i++) cycle(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0, acc);
        idle(14);

        // A routed zero is still active.
        push_wait(3'd6, 1'b0);
        idle(4);

        // Flush during the second cycle of the first of three entries.
        cycle(1'b1, 3'd1, 1'b1, 1'b0, acc);
        cycle(1'b1, 3'd2, 1'b1, 1'b0, acc);
        cycle(1'b1, 3'd3, 1'b0, 1'b0, acc);
        cycle(1'b1, 3'd4, 1'b1, 1'b1, acc);
        idle(3);

        // Asynchronous reset in the middle of a presentation, then resume.
        push_wait(3'd7, 1'b1);
        push_wait(3'd2, 1'b1);
        async_reset();
        push_wait(3'd3, 1'b1);
        idle(4);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0, acc);
        end
        idle(2 * DEPTH * HOLD + 4);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
